// File: rtl/acc_fetch_ctrl_pkg.sv
// ISA definitions for the accumulator fetch/decode controller: opcodes,
// controller states and instruction field positions.
package acc_isa_pkg;

  localparam int INST_W   = 9;
  localparam int OPC_MSB  = 8;
  localparam int OPC_LSB  = 5;
  localparam int FLAG_BIT = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;
  localparam int OFS_MSB  = 4;
  localparam int OFS_W    = OFS_MSB + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOVA = 4'h2,
    OP_MOVR = 4'h3,
    OP_ALU  = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_BZ   = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

endpackage

// File: rtl/acc_fetch_ctrl_if.sv
// Signal bundle between the fetch/decode controller (master) and its
// surroundings: instruction ROM, accumulator, register file and memory.
interface acc_fetch_ctrl_if #(
  parameter int W  = 8,
  parameter int PW = 10
);

  // Memory handshake: Mem_Req stays high with Mem_Write and Reg_Addr stable
  // until Mem_Ack; the transfer completes in the cycle where both are high.
  logic                          Start;
  logic [acc_isa_pkg::INST_W-1:0] Inst;
  logic                          Acc_Zero;
  logic                          Mem_Ack;

  logic [PW-1:0]  PC;
  logic           Acc_Write_En;
  logic           From_Reg;
  logic           From_Imm;
  logic           From_ALU;
  logic           Load_Hi;
  logic [W/2-1:0] Imm_Out;
  logic [3:0]     Alu_Op;
  logic [3:0]     Reg_Addr;
  logic           Reg_Write_En;
  logic           Reg_In_Sel_Mem;
  logic           Mem_Req;
  logic           Mem_Write;
  logic           Done;

  modport master (
    input  Start, Inst, Acc_Zero, Mem_Ack,
    output PC, Acc_Write_En, From_Reg, From_Imm, From_ALU, Load_Hi, Imm_Out,
           Alu_Op, Reg_Addr, Reg_Write_En, Reg_In_Sel_Mem, Mem_Req, Mem_Write,
           Done
  );

  modport slave (
    output Start, Inst, Acc_Zero, Mem_Ack,
    input  PC, Acc_Write_En, From_Reg, From_Imm, From_ALU, Load_Hi, Imm_Out,
           Alu_Op, Reg_Addr, Reg_Write_En, Reg_In_Sel_Mem, Mem_Req, Mem_Write,
           Done
  );

endinterface

// File: rtl/acc_fetch_ctrl.sv
// Fetch/decode controller: steps one instruction at a time through FETCH and
// EXEC, stalls in MEM_WAIT for memory, and parks in HALT.
module acc_fetch_ctrl
  import acc_isa_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 10
) (
  input  logic             clk,
  input  logic             Reset_n,
  acc_fetch_ctrl_if.master bus,
  output state_t           o_dbg_state
);

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_pc, w_pc_nxt;
  logic [INST_W-1:0] r_ir, w_ir_nxt;

  logic [INST_W-1:0] w_inst;
  logic [3:0]        w_opc;
  logic [3:0]        w_opnd;
  logic              w_flag;
  logic [OFS_W-1:0]  w_ofs;
  logic              w_is_mem;
  logic              w_mem_phase;

  logic           w_acc_we, w_from_reg, w_from_imm, w_from_alu, w_load_hi;
  logic [W/2-1:0] w_imm;
  logic [3:0]     w_alu_op, w_reg_addr;
  logic           w_reg_we, w_sel_mem, w_mem_req, w_mem_write, w_done;

  function automatic logic [PW-1:0] pc_rel(input logic [PW-1:0] pc,
                                           input logic [OFS_W-1:0] ofs);
    return pc + {{(PW-OFS_W){ofs[OFS_MSB]}}, ofs};
  endfunction

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // A stalled memory op decodes from IR; the ROM output may have moved on.
  assign w_inst      = (r_state == ST_MEM_WAIT) ? r_ir : bus.Inst;
  assign w_opc       = w_inst[OPC_MSB:OPC_LSB];
  assign w_flag      = w_inst[FLAG_BIT];
  assign w_opnd      = w_inst[OPND_MSB:OPND_LSB];
  assign w_ofs       = w_inst[OFS_MSB:0];
  assign w_is_mem    = (w_opc == OP_LD) || (w_opc == OP_ST);
  assign w_mem_phase = ((r_state == ST_EXEC) && w_is_mem) || (r_state == ST_MEM_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_we    = 1'b0;
    w_from_reg  = 1'b0;
    w_from_imm  = 1'b0;
    w_from_alu  = 1'b0;
    w_load_hi   = 1'b0;
    w_imm       = '0;
    w_alu_op    = '0;
    w_reg_addr  = '0;
    w_reg_we    = 1'b0;
    w_sel_mem   = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.Start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = r_pc + 1'b1;
        case (w_opc)
          OP_LDI: begin
            w_acc_we   = 1'b1;
            w_from_imm = 1'b1;
            w_load_hi  = w_flag;
            w_imm      = (W/2)'(w_opnd);
          end
          OP_MOVA: begin
            w_acc_we   = 1'b1;
            w_from_reg = 1'b1;
            w_reg_addr = w_opnd;
          end
          OP_MOVR: begin
            w_reg_we   = 1'b1;
            w_reg_addr = w_opnd;
          end
          OP_ALU: begin
            w_acc_we   = 1'b1;
            w_from_alu = 1'b1;
            w_alu_op   = w_opnd;
          end
          OP_LD, OP_ST: begin
            if (!bus.Mem_Ack) begin
              w_state_nxt = ST_MEM_WAIT;
              w_pc_nxt    = r_pc;
              w_ir_nxt    = w_inst;
            end
          end
          OP_BZ: begin
            if (bus.Acc_Zero) w_pc_nxt = pc_rel(r_pc, w_ofs);
          end
          OP_JMP: begin
            w_pc_nxt = pc_rel(r_pc, w_ofs);
          end
          OP_HALT: begin
            w_state_nxt = ST_HALT;
            w_pc_nxt    = r_pc;
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        if (bus.Mem_Ack) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = r_pc + 1'b1;
        end
      end
      ST_HALT: begin
        w_done = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Memory ops share one request/completion path across EXEC and MEM_WAIT.
    if (w_mem_phase) begin
      w_mem_req   = 1'b1;
      w_mem_write = (w_opc == OP_ST);
      w_reg_addr  = w_opnd;
      if (bus.Mem_Ack && (w_opc == OP_LD)) begin
        w_acc_we   = 1'b1;
        w_from_reg = 1'b1;
        w_sel_mem  = 1'b1;
      end
    end
  end

  assign bus.PC             = r_pc;
  assign bus.Acc_Write_En   = w_acc_we;
  assign bus.From_Reg       = w_from_reg;
  assign bus.From_Imm       = w_from_imm;
  assign bus.From_ALU       = w_from_alu;
  assign bus.Load_Hi        = w_load_hi;
  assign bus.Imm_Out        = w_imm;
  assign bus.Alu_Op         = w_alu_op;
  assign bus.Reg_Addr       = w_reg_addr;
  assign bus.Reg_Write_En   = w_reg_we;
  assign bus.Reg_In_Sel_Mem = w_sel_mem;
  assign bus.Mem_Req        = w_mem_req;
  assign bus.Mem_Write      = w_mem_write;
  assign bus.Done           = w_done;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_acc_fetch_ctrl.sv
// Bench for acc_fetch_ctrl: ROM and memory responder models, an ISA-level
// program walker as reference, and directed timing/boundary scenarios.
module tb_acc_fetch_ctrl;
  import acc_isa_pkg::*;

  localparam int PW    = 10;
  localparam int DEPTH = 1 << PW;

  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] flags;  // acc_we, from_reg, from_imm, from_alu, load_hi, reg_we, sel_mem, mem_write
    logic [3:0] field;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  acc_fetch_ctrl_if #(.W(8), .PW(PW)) bus ();
  state_t dbg_state;

  acc_fetch_ctrl #(.W(8), .PW(PW)) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- environment models ----------------
  logic [8:0] rom [0:DEPTH-1];
  always @(posedge clk) bus.Inst <= rom[bus.PC];

  int   ack_delay = 0;
  int   ack_cnt   = 0;
  logic ack_force = 1'b0;
  initial bus.Mem_Ack = 1'b0;

  always @(negedge clk) begin
    #1;
    if (bus.Mem_Req) begin
      bus.Mem_Ack = (ack_cnt == ack_delay) || ack_force;
      ack_cnt++;
    end else begin
      ack_cnt     = 0;
      bus.Mem_Ack = ack_force;
    end
  end

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;
  logic [PW-1:0] exp_q[$];
  ev_t           exp_ev_q[$];
  int            pc_chg_cyc[$];
  int            ev_cyc[$];
  logic [PW-1:0] prev_pc = '0;
  ev_t           mon_e;
  logic [7:0]    act_flags;
  logic [3:0]    act_field;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    cyc++;
    if (mon_en && Reset_n) begin
      check("acc_sel_onehot",
            int'(bus.From_Reg) + int'(bus.From_Imm) + int'(bus.From_ALU),
            bus.Acc_Write_En ? 1 : 0);
      if (bus.PC != prev_pc) begin
        pc_chg_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pc_extra act=0x%0h exp=none", bus.PC);
        end else begin
          check("pc_seq", 32'(bus.PC), 32'(exp_q.pop_front()));
        end
      end
      if (bus.Acc_Write_En || bus.Reg_Write_En || (bus.Mem_Req && bus.Mem_Ack)) begin
        ev_cyc.push_back(cyc);
        if (exp_ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ev_extra act_we=%0b reg_we=%0b mem=%0b exp=none",
                   bus.Acc_Write_En, bus.Reg_Write_En, bus.Mem_Req);
        end else begin
          mon_e = exp_ev_q.pop_front();
          act_flags = {bus.Acc_Write_En, bus.From_Reg, bus.From_Imm, bus.From_ALU,
                       (mon_e.kind == 4'h1) ? bus.Load_Hi : 1'b0,
                       bus.Reg_Write_En, bus.Reg_In_Sel_Mem, bus.Mem_Write};
          case (mon_e.kind)
            4'h1:                   act_field = bus.Imm_Out;
            4'h4:                   act_field = bus.Alu_Op;
            4'h2, 4'h3, 4'h5, 4'h6: act_field = bus.Reg_Addr;
            default:                act_field = 4'h0;
          endcase
          check("ev", {20'h0, act_flags, act_field}, {20'h0, mon_e.flags, mon_e.field});
        end
      end
    end
    prev_pc = bus.PC;
  end

  // ISA-level walk of the program in rom starting from PC 0.
  task automatic model_run(input int n, input logic az);
    int pc = 0;
    int off;
    logic [8:0] ins;
    ev_t e;
    for (int i = 0; i < n; i++) begin
      ins = rom[pc];
      e = '0;
      e.kind  = ins[8:5];
      e.field = ins[3:0];
      case (ins[8:5])
        4'h1: begin e.flags = {4'b1010, ins[4], 3'b000}; exp_ev_q.push_back(e); end
        4'h2: begin e.flags = 8'b1100_0000; exp_ev_q.push_back(e); end
        4'h3: begin e.flags = 8'b0000_0100; exp_ev_q.push_back(e); end
        4'h4: begin e.flags = 8'b1001_0000; exp_ev_q.push_back(e); end
        4'h5: begin e.flags = 8'b1100_0010; exp_ev_q.push_back(e); end
        4'h6: begin e.flags = 8'b0000_0001; exp_ev_q.push_back(e); end
        default: ;
      endcase
      if (ins[8:5] == 4'hF) return;
      off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
      if ((ins[8:5] == 4'h8) || ((ins[8:5] == 4'h7) && az))
        pc = (pc + off + DEPTH) % DEPTH;
      else
        pc = (pc + 1) % DEPTH;
      exp_q.push_back(PW'(pc));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en    = 1'b0;
    Reset_n   = 1'b0;
    bus.Start = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); exp_ev_q.delete(); pc_chg_cyc.delete(); ev_cyc.delete();
    Reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.Start = 1'b1;
    @(negedge clk); bus.Start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || exp_ev_q.size() != 0) && t < budget) begin
      @(negedge clk); #3; t++;
    end
    check({name, "_drain"}, exp_q.size() + exp_ev_q.size(), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while (!bus.Done && t < budget) begin @(negedge clk); #3; t++; end
    check({name, "_done"}, 32'(bus.Done), 1);
  endtask

  // ---------------- stimulus ----------------
  int req_cyc, bad_addr, ld_pulse, wr_cyc, mw_cyc;
  state_t st_after;
  logic   saw_wr;

  initial begin
    bus.Start    = 1'b0;
    bus.Acc_Zero = 1'b0;
    clear_rom();

    // Reset state
    do_reset();
    @(negedge clk); #3;
    check("reset_outputs",
          {bus.PC, bus.Acc_Write_En, bus.From_Reg, bus.From_Imm, bus.From_ALU, bus.Load_Hi,
           bus.Imm_Out, bus.Alu_Op, bus.Reg_Addr, bus.Reg_Write_En, bus.Reg_In_Sel_Mem,
           bus.Mem_Req, bus.Mem_Write, bus.Done}, 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // LDI lo 5 / LDI hi A
    rom[0] = 9'h025; rom[1] = 9'h03A; rom[2] = 9'h1E0;
    model_run(3, 1'b0);
    check("pin_ldi_count", exp_ev_q.size(), 2);
    check("pin_ldi_lo", 32'(exp_ev_q[0]), 32'({4'h1, 8'b1010_0000, 4'h5}));
    check("pin_ldi_hi", 32'(exp_ev_q[1]), 32'({4'h1, 8'b1010_1000, 4'hA}));
    check("pin_ldi_pcs", exp_q.size(), 2);
    pulse_start();
    wait_drain("ldi", 20);
    wait_done("ldi", 10);
    check("ldi_pc_final", 32'(bus.PC), 2);
    if (pc_chg_cyc.size() >= 2) check("ldi_pc_step_cycles", pc_chg_cyc[1] - pc_chg_cyc[0], 2);
    if (ev_cyc.size() >= 2)     check("ldi_ev_step_cycles", ev_cyc[1] - ev_cyc[0], 2);

    // BZ -2 at PC 5, taken
    clear_rom(); rom[5] = 9'h0FE;
    do_reset();
    bus.Acc_Zero = 1'b1;
    model_run(6, 1'b1);
    check("pin_bz_taken", 32'(exp_q[$]), 3);
    pulse_start();
    wait_drain("bz_taken", 30);
    check("bz_taken_pc", 32'(bus.PC), 3);
    mon_en = 1'b0;

    // BZ -2 at PC 5, not taken
    rom[6] = 9'h1E0;
    do_reset();
    bus.Acc_Zero = 1'b0;
    model_run(7, 1'b0);
    check("pin_bz_not_taken", 32'(exp_q[$]), 6);
    pulse_start();
    wait_drain("bz_nt", 30);
    wait_done("bz_nt", 10);
    check("bz_not_taken_pc", 32'(bus.PC), 6);

    // JMP wrap at both ends of the address space
    clear_rom(); rom[0] = 9'h11F; rom[DEPTH-1] = 9'h101;
    do_reset();
    model_run(2, 1'b0);
    check("pin_jmp_back", 32'(exp_q[0]), DEPTH - 1);
    check("pin_jmp_wrap", 32'(exp_q[1]), 0);
    pulse_start();
    wait_drain("jmp", 20);
    check("jmp_wrap_pc", 32'(bus.PC), 0);
    mon_en = 1'b0;

    // LD with ack three cycles late
    clear_rom(); rom[0] = 9'h021; rom[1] = 9'h0A3; rom[2] = 9'h1E0;
    do_reset();
    ack_delay = 3;
    model_run(3, 1'b0);
    pulse_start();
    req_cyc = 0; bad_addr = 0; ld_pulse = 0; mw_cyc = 0;
    for (int t = 0; t < 60 && !bus.Done; t++) begin
      @(negedge clk); #3;
      if (bus.Mem_Req) begin
        req_cyc++;
        if (bus.Reg_Addr != 4'h3 || bus.Mem_Write) bad_addr++;
      end
      if (dbg_state == ST_MEM_WAIT) mw_cyc++;
      if (bus.Acc_Write_En && bus.Reg_In_Sel_Mem && bus.From_Reg) ld_pulse++;
    end
    check("ld_req_cycles", req_cyc, 4);
    check("ld_addr_stable", bad_addr, 0);
    check("ld_wait_cycles", mw_cyc, 3);
    check("ld_acc_pulse", ld_pulse, 1);
    wait_drain("ld", 5);
    wait_done("ld", 5);
    check("ld_pc_final", 32'(bus.PC), 2);

    // ST acked in EXEC
    clear_rom(); rom[0] = 9'h0C2; rom[1] = 9'h1E0;
    do_reset();
    ack_delay = 0;
    model_run(2, 1'b0);
    pulse_start();
    wr_cyc = 0; saw_wr = 1'b0; st_after = ST_IDLE;
    for (int t = 0; t < 30 && !bus.Done; t++) begin
      @(negedge clk); #3;
      if (saw_wr) begin st_after = dbg_state; saw_wr = 1'b0; end
      if (bus.Mem_Write) begin wr_cyc++; saw_wr = 1'b1; end
    end
    check("st_write_cycles", wr_cyc, 1);
    check("st_next_state", 32'(st_after), 32'(ST_FETCH));
    wait_drain("st", 5);
    check("st_pc_final", 32'(bus.PC), 1);

    // Reset in the middle of MEM_WAIT, then a stray ack
    clear_rom(); rom[0] = 9'h0A4;
    do_reset();
    ack_delay = 100;
    pulse_start();
    for (int t = 0; t < 10 && dbg_state != ST_MEM_WAIT; t++) begin @(negedge clk); #3; end
    check("rst_reached_wait", 32'(dbg_state), 32'(ST_MEM_WAIT));
    @(negedge clk);
    Reset_n = 1'b0;
    @(negedge clk); #3;
    check("rst_wait_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_wait_pc", 32'(bus.PC), 0);
    check("rst_wait_req", 32'(bus.Mem_Req), 0);
    Reset_n   = 1'b1;
    ack_force = 1'b1;
    @(negedge clk); ack_force = 1'b0;
    #3;
    check("late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    check("late_ack_pc", 32'(bus.PC), 0);
    check("late_ack_acc_we", 32'(bus.Acc_Write_En), 0);

    // Undefined opcode as NOP, HALT at PC 7 with Start pulses
    clear_rom(); rom[3] = 9'h140; rom[7] = 9'h1E0;
    do_reset();
    model_run(8, 1'b0);
    check("pin_halt_pcs", exp_q.size(), 7);
    check("pin_halt_events", exp_ev_q.size(), 0);
    pulse_start();
    wait_drain("halt", 40);
    wait_done("halt", 10);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.Start = (t % 5 == 2);
      #3;
      check("halt_done", 32'(bus.Done), 1);
      check("halt_pc", 32'(bus.PC), 7);
    end
    bus.Start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
